// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM states and the IF/ID pipeline register layout.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam word_t PC_STEP_DFLT = 32'd4;
    localparam word_t WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        SKID   = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic  valid;
        word_t instr;
        word_t npc;
    } ifid_t;

    function automatic word_t word_align(input word_t addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for an instruction word that returns while ID is stalled.
module fetch_skid_buf
    import cpu_types_pkg::*;
(
    input  logic  clk_sys,
    input  logic  rst_b,
    input  logic  load,
    input  logic  unload,
    input  logic  flush,
    input  ifid_t data_in,
    output logic  full,
    output ifid_t data_out
);

    ifid_t entry;
    logic  entry_full;

    always_ff @(posedge clk_sys) begin
        if (!rst_b) begin
            entry      <= '0;
            entry_full <= 1'b0;
        end else if (flush) begin
            entry_full <= 1'b0;
        end else if (load) begin
            entry      <= data_in;
            entry_full <= 1'b1;
        end else if (unload) begin
            entry_full <= 1'b0;
        end
    end

    assign full     = entry_full;
    assign data_out = entry;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, drives the imem request/hit handshake and loads the IF/ID register.
//
// state  | meaning
// FETCH  | request at pc outstanding, IF/ID loads on hit
// SKID   | word returned under stall is parked in the skid buffer, no request
// DRAIN  | redirect arrived mid-request; wait for the stale hit, then jump
// HALTED | HALT decoded; fetch stopped until reset
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000,
    parameter word_t PC_STEP = PC_STEP_DFLT
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  ihit,
    input  word_t iload,
    output logic  imemREN,
    output word_t imemaddr,
    input  logic  stall,
    input  logic  redirect,
    input  word_t redirect_pc,
    input  logic  halt,
    output logic  ifid_valid,
    output word_t ifid_instr,
    output word_t ifid_npc
);

    fetch_state_t state;
    word_t        pc;
    word_t        target;
    logic         req_seen;
    ifid_t        ifid;

    word_t        pc_seq;
    word_t        redirect_tgt;

    logic         skid_load;
    logic         skid_unload;
    logic         skid_flush;
    logic         skid_full;
    ifid_t        skid_data;
    ifid_t        fetched;

    assign pc_seq       = pc + PC_STEP;
    assign redirect_tgt = word_align(redirect_pc);
    assign fetched      = '{valid: 1'b1, instr: iload, npc: pc_seq};

    always_comb begin
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_flush  = 1'b0;
        if (state != HALTED) begin
            if (redirect || halt) begin
                skid_flush = 1'b1;
            end else begin
                skid_load   = (state == FETCH) && ihit && stall && ifid.valid;
                skid_unload = (state == SKID) && !stall;
            end
        end
    end

    fetch_skid_buf u_skid (
        .clk_sys  (CLK),
        .rst_b    (nRST),
        .load     (skid_load),
        .unload   (skid_unload),
        .flush    (skid_flush),
        .data_in  (fetched),
        .full     (skid_full),
        .data_out (skid_data)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= FETCH;
            pc       <= word_align(PC_INIT);
            target   <= '0;
            req_seen <= 1'b0;
            ifid     <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        ifid.valid <= 1'b0;
                        req_seen   <= 1'b0;
                        // Memory already holds this address; keep it stable until the hit.
                        if (!ihit && req_seen) begin
                            target <= redirect_tgt;
                            state  <= DRAIN;
                        end else begin
                            pc <= redirect_tgt;
                        end
                    end else if (halt) begin
                        req_seen <= 1'b0;
                        state    <= HALTED;
                    end else if (ihit) begin
                        req_seen <= 1'b0;
                        pc       <= pc_seq;
                        if (stall && ifid.valid) begin
                            state <= SKID;
                        end else begin
                            ifid <= fetched;
                        end
                    end else begin
                        req_seen <= 1'b1;
                        if (!stall) begin
                            ifid.valid <= 1'b0;
                        end
                    end
                end
                SKID: begin
                    if (redirect) begin
                        ifid.valid <= 1'b0;
                        pc         <= redirect_tgt;
                        state      <= FETCH;
                    end else if (halt) begin
                        state <= HALTED;
                    end else if (!stall && skid_full) begin
                        ifid  <= skid_data;
                        state <= FETCH;
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        ifid.valid <= 1'b0;
                        if (ihit) begin
                            pc    <= redirect_tgt;
                            state <= FETCH;
                        end else begin
                            target <= redirect_tgt;
                        end
                    end else if (halt) begin
                        state <= HALTED;
                    end else if (ihit) begin
                        pc    <= target;
                        state <= FETCH;
                    end
                end
                HALTED: begin
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    assign imemREN    = nRST && ((state == FETCH) || (state == DRAIN));
    assign imemaddr   = word_align(pc);
    assign ifid_valid = ifid.valid;
    assign ifid_instr = ifid.instr;
    assign ifid_npc   = ifid.npc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit;
    logic [31:0] iload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_npc;

    int errors = 0;
    int checks = 0;

    fetch_unit #(.PC_INIT(32'h0000_0000), .PC_STEP(32'd4)) u_dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .iload       (iload),
        .imemREN     (imemREN),
        .imemaddr    (imemaddr),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .ifid_valid  (ifid_valid),
        .ifid_instr  (ifid_instr),
        .ifid_npc    (ifid_npc)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ihit        = 1'b0;
        iload       = 32'h0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        halt        = 1'b0;
    endtask

    initial begin
        nRST = 1'b0;
        idle_inputs();
        #1;
        chk("ren_during_reset", {31'b0, imemREN}, 32'd0);
        tick();
        chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
        chk("rst_instr", ifid_instr, 32'h0);
        chk("rst_npc", ifid_npc, 32'h0);
        chk("rst_addr", imemaddr, 32'h0);
        nRST = 1'b1;
        #1;
        chk("ren_after_reset", {31'b0, imemREN}, 32'd1);

        // sequential fetch with a hit every cycle
        for (int i = 0; i < 3; i++) begin
            chk("seq_addr", imemaddr, 32'(4 * i));
            ihit  = 1'b1;
            iload = 32'h2001_0001 + 32'(i);
            tick();
            chk("seq_valid", {31'b0, ifid_valid}, 32'd1);
            chk("seq_instr", ifid_instr, 32'h2001_0001 + 32'(i));
            chk("seq_npc", ifid_npc, 32'(4 * (i + 1)));
        end

        // hit under stall parks in skid; IF/ID holds until stall releases
        stall = 1'b1;
        ihit  = 1'b1;
        iload = 32'h2001_0004;
        tick();
        chk("skid_ren", {31'b0, imemREN}, 32'd0);
        chk("skid_hold_instr", ifid_instr, 32'h2001_0003);
        chk("skid_hold_npc", ifid_npc, 32'd12);
        ihit  = 1'b0;
        iload = 32'hFFFF_FFFF;
        tick();
        chk("skid_ren2", {31'b0, imemREN}, 32'd0);
        chk("skid_hold_valid", {31'b0, ifid_valid}, 32'd1);
        chk("skid_hold_npc2", ifid_npc, 32'd12);
        stall = 1'b0;
        tick();
        chk("skid_out_instr", ifid_instr, 32'h2001_0004);
        chk("skid_out_npc", ifid_npc, 32'd16);
        chk("skid_out_valid", {31'b0, ifid_valid}, 32'd1);
        chk("resume_ren", {31'b0, imemREN}, 32'd1);
        chk("resume_addr", imemaddr, 32'h10);

        // redirect while request at 0x10 outstanding -> drain stale hit
        ihit = 1'b0;
        tick();
        chk("bubble_valid", {31'b0, ifid_valid}, 32'd0);
        chk("pend_addr", imemaddr, 32'h10);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        tick();
        redirect = 1'b0;
        chk("drain_addr", imemaddr, 32'h10);
        chk("drain_ren", {31'b0, imemREN}, 32'd1);
        chk("drain_valid", {31'b0, ifid_valid}, 32'd0);
        tick();
        chk("drain_addr2", imemaddr, 32'h10);
        ihit  = 1'b1;
        iload = 32'hDEAD_BEEF;
        tick();
        chk("drain_done_addr", imemaddr, 32'h100);
        chk("drain_discard_valid", {31'b0, ifid_valid}, 32'd0);
        iload = 32'h2001_0100;
        tick();
        chk("tgt_instr", ifid_instr, 32'h2001_0100);
        chk("tgt_npc", ifid_npc, 32'h104);
        chk("tgt_valid", {31'b0, ifid_valid}, 32'd1);

        // redirect beats halt and stall, then halt alone freezes the stage
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        halt        = 1'b1;
        stall       = 1'b1;
        ihit        = 1'b1;
        iload       = 32'h1111_1111;
        tick();
        chk("rh_addr", imemaddr, 32'h200);
        chk("rh_ren", {31'b0, imemREN}, 32'd1);
        chk("rh_valid", {31'b0, ifid_valid}, 32'd0);
        redirect = 1'b0;
        stall    = 1'b0;
        iload    = 32'h2222_2222;
        tick();
        chk("halt_ren", {31'b0, imemREN}, 32'd0);
        halt        = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halted_ren", {31'b0, imemREN}, 32'd0);
            chk("halted_addr", imemaddr, 32'h200);
            chk("halted_valid", {31'b0, ifid_valid}, 32'd0);
            chk("halted_npc", ifid_npc, 32'h104);
        end
        nRST = 1'b0;
        idle_inputs();
        tick();
        nRST = 1'b1;

        // pc wraps from the top of the address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect = 1'b0;
        chk("wrap_start_addr", imemaddr, 32'hFFFF_FFFC);
        ihit  = 1'b1;
        iload = 32'h1234_5678;
        tick();
        chk("wrap_addr", imemaddr, 32'h0);
        chk("wrap_npc", ifid_npc, 32'h0);
        chk("wrap_instr", ifid_instr, 32'h1234_5678);

        // reset while in SKID with a redirect pending
        stall = 1'b1;
        iload = 32'hAAAA_0001;
        tick();
        chk("skid2_ren", {31'b0, imemREN}, 32'd0);
        nRST        = 1'b0;
        ihit        = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        #1;
        chk("rst2_ren_low", {31'b0, imemREN}, 32'd0);
        tick();
        chk("rst2_addr", imemaddr, 32'h0);
        chk("rst2_valid", {31'b0, ifid_valid}, 32'd0);
        chk("rst2_instr", ifid_instr, 32'h0);
        chk("rst2_npc", ifid_npc, 32'h0);
        nRST = 1'b1;
        idle_inputs();
        #1;
        chk("rst2_ren_high", {31'b0, imemREN}, 32'd1);
        tick();
        chk("rst2_no_stale", {31'b0, ifid_valid}, 32'd0);
        chk("rst2_addr_hold", imemaddr, 32'h0);
        ihit  = 1'b1;
        iload = 32'h5555_0000;
        tick();
        chk("rst2_first_instr", ifid_instr, 32'h5555_0000);
        chk("rst2_first_npc", ifid_npc, 32'h4);
        chk("rst2_first_valid", {31'b0, ifid_valid}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
